// File: rtl/dcache1_inval_sched_pkg.sv
// Shared constants and types for the dcache1 invalidation scheduler.
package dcache1_inval_sched_pkg;
  localparam int DC1_NREQ      = 4;
  localparam int DC1_QDEPTH    = 16;
  localparam int DC1_INV_SLOTS = 6;
  localparam int DC1_SETS      = 128;
  localparam int DC1_SETIDX_W  = 7;

  typedef logic [DC1_SETIDX_W-1:0] dc1_setidx_t;

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} dc1_inv_state_e;
endpackage

// File: rtl/dcache1_inval_sched_if.sv
// Requester, flush and tag puke-bus signals of the invalidation scheduler.
interface dcache1_inval_sched_if;
  import dcache1_inval_sched_pkg::*;

  logic                                init_busy;
  logic                                hold;
  logic [DC1_NREQ-1:0]                 req_valid;
  dc1_setidx_t [DC1_NREQ-1:0]          req_addr;
  logic [DC1_NREQ-1:0]                 req_ready;
  logic                                flush_req;
  logic                                flush_busy;
  logic                                flush_done;
  logic [DC1_INV_SLOTS-1:0]            puke_en;
  dc1_setidx_t [DC1_INV_SLOTS-1:0]     puke_addr;
  logic [4:0]                          q_count;

  modport master (
    output init_busy, hold, req_valid, req_addr, flush_req,
    input  req_ready, flush_busy, flush_done, puke_en, puke_addr, q_count
  );

  modport slave (
    input  init_busy, hold, req_valid, req_addr, flush_req,
    output req_ready, flush_busy, flush_done, puke_en, puke_addr, q_count
  );
endinterface

// File: rtl/dcache1_inval_sched_fifo.sv
// Circular invalidate FIFO: up to 4 pushes and 6 pops per cycle, with an
// occupancy counter so a 4-bit pointer wrap can tell full from empty.
module dc1_inv_fifo
  import dcache1_inval_sched_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2:0]                      push_n,
  input  dc1_setidx_t [DC1_NREQ-1:0]      push_data,
  input  logic [2:0]                      pop_n,
  output dc1_setidx_t [DC1_INV_SLOTS-1:0] head_data,
  output logic [4:0]                      count
);
  dc1_setidx_t mem [DC1_QDEPTH];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + 4'(push_n);
      rd_ptr <= rd_ptr + 4'(pop_n);
      count  <= count + 5'(push_n) - 5'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DC1_NREQ; i++)
      if (3'(i) < push_n) mem[wr_ptr + 4'(i)] <= push_data[i];
  end

  always_comb begin
    for (int i = 0; i < DC1_INV_SLOTS; i++)
      head_data[i] = mem[rd_ptr + 4'(i)];
  end
endmodule

// File: rtl/dcache1_inval_sched.sv
// Invalidation scheduler: round-robin request intake, 6-slot dispatch, flush sweep.
// IDLE: accept + dispatch | DRAIN: dispatch only, empty queue | SWEEP: issue set indices 0..127
module dcache1_inval_sched
  import dcache1_inval_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  dcache1_inval_sched_if.slave  bus
);
  dc1_inv_state_e                  state, state_nxt;
  logic [7:0]                      sweep_ptr, sweep_nxt;
  logic [1:0]                      rr_ptr, rr_nxt;
  logic [4:0]                      q_count, free;
  logic                            stall, disp_en;
  logic [1:0]                      rank [DC1_NREQ];
  logic [DC1_NREQ-1:0]             ready;
  logic [2:0]                      push_n, pop_n;
  dc1_setidx_t [DC1_NREQ-1:0]      push_data;
  dc1_setidx_t [DC1_INV_SLOTS-1:0] head_data, addr_d, addr_q;
  logic [DC1_INV_SLOTS-1:0]        en_d, en_q;
  logic                            done_d, done_q;

  assign stall   = bus.init_busy | bus.hold;
  assign free    = 5'(DC1_QDEPTH) - q_count;
  assign disp_en = ~stall & ((state == IDLE) | (state == DRAIN));

  dc1_inv_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .head_data (head_data),
    .count     (q_count)
  );

  // Rank = number of valid requesters ahead of k in round-robin order from rr_ptr.
  always_comb begin
    ready     = '0;
    push_n    = '0;
    push_data = '0;
    rr_nxt    = rr_ptr;
    for (int k = 0; k < DC1_NREQ; k++) begin
      rank[k] = '0;
      for (int j = 0; j < DC1_NREQ; j++)
        if (bus.req_valid[j] && ((2'(j) - rr_ptr) < (2'(k) - rr_ptr)))
          rank[k] = rank[k] + 2'd1;
    end
    for (int k = 0; k < DC1_NREQ; k++) begin
      if ((state == IDLE) && bus.req_valid[k] && (5'(rank[k]) < free)) begin
        ready[k]          = 1'b1;
        push_data[rank[k]] = bus.req_addr[k];
        push_n            = push_n + 3'd1;
      end
    end
    for (int o = 0; o < DC1_NREQ; o++)
      if (ready[rr_ptr + 2'(o)]) rr_nxt = rr_ptr + 2'(o) + 2'd1;
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_ptr;
    pop_n     = '0;
    en_d      = '0;
    addr_d    = addr_q;
    done_d    = 1'b0;
    if (disp_en)
      pop_n = (q_count > 5'(DC1_INV_SLOTS)) ? 3'(DC1_INV_SLOTS) : q_count[2:0];
    for (int i = 0; i < DC1_INV_SLOTS; i++) begin
      if (3'(i) < pop_n) begin
        en_d[i]   = 1'b1;
        addr_d[i] = head_data[i];
      end
    end
    case (state)
      IDLE:  if (bus.flush_req) state_nxt = DRAIN;
      DRAIN: if (q_count == '0) begin
        state_nxt = SWEEP;
        sweep_nxt = '0;
      end
      SWEEP: if (!stall) begin
        for (int i = 0; i < DC1_INV_SLOTS; i++) begin
          if ((sweep_ptr + 8'(i)) < 8'(DC1_SETS)) begin
            en_d[i]   = 1'b1;
            addr_d[i] = 7'(sweep_ptr + 8'(i));
          end
        end
        sweep_nxt = sweep_ptr + 8'(DC1_INV_SLOTS);
        if ((sweep_ptr + 8'(DC1_INV_SLOTS)) >= 8'(DC1_SETS)) begin
          state_nxt = IDLE;
          done_d    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sweep_ptr <= '0;
      rr_ptr    <= '0;
      en_q      <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= sweep_nxt;
      rr_ptr    <= rr_nxt;
      en_q      <= en_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.puke_en    = en_q;
  assign bus.puke_addr  = addr_q;
  assign bus.flush_done = done_q;
  assign bus.flush_busy = (state != IDLE);
  assign bus.q_count    = q_count;
endmodule

// File: tb/tb_dcache1_inval_sched.sv
// Directed bench for dcache1_inval_sched: intake, dispatch, flush sweep, stalls, reset abort.
module tb_dcache1_inval_sched;
  import dcache1_inval_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache1_inval_sched_if bus();

  dcache1_inval_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  dc1_setidx_t      exp_q[$];
  dc1_setidx_t [5:0] e_addr;
  dc1_setidx_t [5:0] last_addr;
  logic [5:0]       last_en;
  logic [127:0]     seen;
  int               dups, issues, dones;
  bit               found;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic track_outputs();
    if (bus.puke_en != '0) issues++;
    for (int i = 0; i < 6; i++) begin
      if (bus.puke_en[i]) begin
        if (seen[bus.puke_addr[i]]) dups++;
        seen[bus.puke_addr[i]] = 1'b1;
      end
    end
    if (bus.flush_done) begin
      dones++;
      last_en   = bus.puke_en;
      last_addr = bus.puke_addr;
    end
  endtask

  initial begin
    bus.init_busy = 1'b0;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.flush_req = 1'b0;
    e_addr        = '0;
    last_addr     = '0;
    last_en       = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {bus.puke_en, bus.q_count, bus.flush_busy, bus.flush_done, bus.req_ready}, 64'd0);
    chk("reset_addr", bus.puke_addr, 64'd0);
    rst = 1'b0;
    tick();

    // Single request, single dispatch
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 7'h45;
    #1;
    chk("t1_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("t1_q_after_push", bus.q_count, 5'd1);
    chk("t1_no_bypass", bus.puke_en, 6'd0);
    tick();
    chk("t1_en", bus.puke_en, 6'b000001);
    chk("t1_addr0", bus.puke_addr[0], 7'h45);
    chk("t1_q_empty", bus.q_count, 5'd0);

    // Fill under hold from rr_ptr=1, then drain 6/6/4
    bus.hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) bus.req_addr[k] = 7'(16 * c + k);
      bus.req_valid = 4'hF;
      exp_q.push_back(7'(16 * c + 1));
      exp_q.push_back(7'(16 * c + 2));
      exp_q.push_back(7'(16 * c + 3));
      exp_q.push_back(7'(16 * c + 0));
      #1;
      chk("t2_ready_all", bus.req_ready, 4'hF);
      tick();
    end
    chk("t2_q_full", bus.q_count, 5'd16);
    chk("t2_ready_full", bus.req_ready, 4'h0);
    chk("t2_hold_no_en", bus.puke_en, 6'd0);
    bus.req_valid = '0;
    bus.hold = 1'b0;
    for (int d = 0; d < 3; d++) begin
      tick();
      for (int i = 0; i < 6; i++)
        if (6 * d + i < 16) e_addr[i] = exp_q[6 * d + i];
      chk("t2_drain_en", bus.puke_en, (d < 2) ? 6'h3F : 6'h0F);
      chk("t2_drain_q", bus.q_count, (d == 0) ? 5'd10 : (d == 1) ? 5'd4 : 5'd0);
      chk("t2_drain_addr", bus.puke_addr, e_addr);
    end

    // Round-robin with limited free space
    bus.hold = 1'b1;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'hF;
    repeat (3) tick();
    bus.req_valid = 4'b0011;
    tick();
    chk("t3_q15", bus.q_count, 5'd15);
    bus.req_valid = 4'b1001;
    #1;
    chk("t3_ready_rr2_free1", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    chk("t3_q16", bus.q_count, 5'd16);
    bus.hold = 1'b0;
    tick();
    bus.hold = 1'b1;
    chk("t3_q10", bus.q_count, 5'd10);
    bus.req_valid = 4'hF;
    tick();
    #1;
    chk("t3_ready_rr0_free2", bus.req_ready, 4'b0011);
    tick();
    bus.req_valid = '0;
    chk("t3_q16b", bus.q_count, 5'd16);
    bus.hold = 1'b0;
    repeat (3) tick();
    chk("t3_drained", bus.q_count, 5'd0);
    tick();

    // Flush with 3 queued
    bus.hold = 1'b1;
    for (int k = 0; k < 4; k++) bus.req_addr[k] = 7'(8'h50 + k);
    bus.req_valid = 4'b0111;
    tick();
    bus.req_valid = '0;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    chk("t4_busy", bus.flush_busy, 1'b1);
    bus.req_valid = 4'hF;
    #1;
    chk("t4_ready_drain", bus.req_ready, 4'h0);
    bus.req_valid = '0;
    bus.hold = 1'b0;
    tick();
    chk("t4_drain_en", bus.puke_en, 6'b000111);
    chk("t4_drain_q", bus.q_count, 5'd0);
    tick();
    chk("t4_transition_en", bus.puke_en, 6'd0);
    seen = '0; dups = 0; issues = 0; dones = 0;
    repeat (30) begin
      tick();
      track_outputs();
    end
    chk("t4_issue_cycles", 64'(issues), 64'd22);
    chk("t4_all_sets", 64'(&seen), 64'd1);
    chk("t4_dups", 64'(dups), 64'd0);
    chk("t4_done_count", 64'(dones), 64'd1);
    chk("t4_last_en", last_en, 6'b000011);
    chk("t4_last_addr", {last_addr[1], last_addr[0]}, {7'd127, 7'd126});
    chk("t4_idle", bus.flush_busy, 1'b0);

    // Reset in mid-sweep
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.puke_en[0] && bus.puke_addr[0] == 7'd54) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reached_54", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {bus.puke_en, bus.flush_busy, bus.flush_done, bus.q_count}, 64'd0);
    tick();
    rst = 1'b0;
    seen = '0; dups = 0; issues = 0; dones = 0;
    repeat (30) begin
      tick();
      track_outputs();
    end
    chk("t6_no_done", 64'(dones), 64'd0);
    chk("t6_no_issue", 64'(issues), 64'd0);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick();
    tick();
    chk("t6_restart_en", bus.puke_en, 6'h3F);
    chk("t6_restart_addr", {bus.puke_addr[5], bus.puke_addr[0]}, {7'd5, 7'd0});
    repeat (25) tick();
    chk("t6_restart_idle", bus.flush_busy, 1'b0);

    // init_busy after reset with requests pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.init_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) bus.req_addr[k] = 7'(8'h40 + 4 * c + k);
      bus.req_valid = 4'hF;
      tick();
    end
    bus.req_valid = '0;
    issues = 0;
    repeat (61) begin
      if (bus.puke_en != '0) issues++;
      tick();
    end
    chk("t5_no_en_init", 64'(issues), 64'd0);
    chk("t5_q12", bus.q_count, 5'd12);
    bus.init_busy = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) e_addr[i] = 7'(8'h40 + i);
    chk("t5_en_a", bus.puke_en, 6'h3F);
    chk("t5_addr_a", bus.puke_addr, e_addr);
    tick();
    for (int i = 0; i < 6; i++) e_addr[i] = 7'(8'h46 + i);
    chk("t5_en_b", bus.puke_en, 6'h3F);
    chk("t5_addr_b", bus.puke_addr, e_addr);
    chk("t5_q0", bus.q_count, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
